// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// The font table is indexed by nibble value and stored active-high (g..a).
package seg_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 8;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        DWELL = 2'd1,
        GAP   = 2'd2
    } scan_state_t;

    localparam logic [15:0][6:0] FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  blank;
        logic [7:0]  dp;
    } frame_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame-update handshake between an upstream formatter and the scan controller.
interface seg_scan_ctrl_if;

    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_data;
    logic [7:0]  upd_blank;
    logic [7:0]  upd_dp;

    modport master (output upd_valid, upd_data, upd_blank, upd_dp, input upd_ready);
    modport slave  (input upd_valid, upd_data, upd_blank, upd_dp, output upd_ready);

endinterface

// File: rtl/seg_scan_ctrl_hex_to_seg7.sv
// Nibble to segment byte {dp,g..a}; blanking also suppresses the decimal point.
module hex_to_seg7
    import seg_scan_ctrl_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] seg
);

    logic [7:0] lit;

    always_comb begin
        lit = blank ? 8'h00 : {dp, FONT[nibble]};
        seg = ACTIVE_LOW ? ~lit : lit;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit seven-segment scan controller with a double-buffered frame that is
// committed only at frame boundaries, plus a dead cycle between digits.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV    = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  upd,
    output logic [7:0]      seg_out,
    output logic [7:0]      an_out,
    output logic            frame_done
);

    localparam int              CW         = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0]   DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [2:0]      LAST_DIGIT = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]      OFF        = ACTIVE_LOW ? 8'hFF : 8'h00;

    scan_state_t   state, state_n;
    logic [2:0]    digit_idx, idx_n, show_idx;
    logic [CW-1:0] div_cnt, cnt_n;
    frame_t        act_frame, pend_frame, src_frame;
    logic          pend_full, pend_full_n, ready_q;
    logic          accept, commit, show, fd_n;
    logic [7:0]    lit_seg, seg_n, an_n, onehot;

    assign upd.upd_ready = ready_q;
    assign accept        = upd.upd_valid && ready_q;

    // Next-state logic also decides which digit (if any) the registered
    // outputs will show, so anodes change on the same edge as the state.
    always_comb begin
        state_n  = state;
        idx_n    = digit_idx;
        cnt_n    = div_cnt;
        commit   = 1'b0;
        show     = 1'b0;
        show_idx = digit_idx;
        fd_n     = 1'b0;
        case (state)
            BLANK: begin
                if (pend_full) begin
                    commit   = 1'b1;
                    state_n  = DWELL;
                    idx_n    = 3'd0;
                    cnt_n    = '0;
                    show     = 1'b1;
                    show_idx = 3'd0;
                end
            end
            DWELL: begin
                if (div_cnt == DIV_LAST) begin
                    state_n = GAP;
                    fd_n    = (digit_idx == LAST_DIGIT);
                end else begin
                    cnt_n = div_cnt + CW'(1);
                    show  = 1'b1;
                end
            end
            GAP: begin
                state_n  = DWELL;
                idx_n    = digit_idx + 3'd1;
                cnt_n    = '0;
                commit   = pend_full && (digit_idx == LAST_DIGIT);
                show     = 1'b1;
                show_idx = digit_idx + 3'd1;
            end
            default: state_n = BLANK;
        endcase
        pend_full_n = accept ? 1'b1 : (commit ? 1'b0 : pend_full);
    end

    // A committing edge already displays the incoming frame's digit 0.
    always_comb begin
        src_frame = commit ? pend_frame : act_frame;
        onehot    = 8'b1 << show_idx;
        an_n      = show ? (ACTIVE_LOW ? ~onehot : onehot) : OFF;
        seg_n     = show ? lit_seg : OFF;
    end

    hex_to_seg7 #(.ACTIVE_LOW(ACTIVE_LOW)) u_font (
        .nibble (src_frame.data[{show_idx, 2'b00} +: 4]),
        .blank  (src_frame.blank[show_idx]),
        .dp     (src_frame.dp[show_idx]),
        .seg    (lit_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BLANK;
            digit_idx  <= 3'd0;
            div_cnt    <= '0;
            act_frame  <= '0;
            pend_frame <= '0;
            pend_full  <= 1'b0;
            ready_q    <= 1'b1;
            seg_out    <= OFF;
            an_out     <= OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            digit_idx  <= idx_n;
            div_cnt    <= cnt_n;
            pend_full  <= pend_full_n;
            ready_q    <= !pend_full_n;
            seg_out    <= seg_n;
            an_out     <= an_n;
            frame_done <= fd_n;
            if (accept)
                pend_frame <= '{data: upd.upd_data, blank: upd.upd_blank, dp: upd.upd_dp};
            if (commit)
                act_frame <= pend_frame;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected digits are queued by the stimulus
// thread and checked by a monitor each time a new anode becomes active.
module tb_seg_scan_ctrl;

    localparam int TB_DIV    = 4;
    localparam int TB_PERIOD = 40;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] seg_out, an_out;
    logic       frame_done;

    int pass_cnt = 0;
    int total_cnt = 0;
    int digit_starts = 0;
    logic [15:0] exp_q[$];

    seg_scan_ctrl_if upd_if ();

    seg_scan_ctrl #(.CLK_DIV(TB_DIV), .ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .upd        (upd_if),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_done (frame_done)
    );

    initial forever #5 if (clk_en) clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic [7:0] blank, input logic [7:0] dp);
        bit done = 0;
        @(posedge clk);
        #1;
        upd_if.upd_valid = 1'b1;
        upd_if.upd_data  = data;
        upd_if.upd_blank = blank;
        upd_if.upd_dp    = dp;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (upd_if.upd_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        upd_if.upd_valid = 1'b0;
        if (!done) begin
            total_cnt++;
            $display("[TB] FAIL accept_timeout: got no upd_ready, expected acceptance of %0h", data);
        end
    endtask

    task automatic waitQueueEmpty(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending digits, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: pops one expectation per digit presentation, and checks dwell
    // length and frame_done placement/period on the side.
    initial begin
        logic [7:0]  prev_an = 8'hFF;
        logic        prev_fd = 1'b0;
        int          run = 0;
        int          cyc = 0;
        int          last_fd = -1;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_an = 8'hFF;
                prev_fd = 1'b0;
                run     = 0;
                last_fd = -1;
            end else begin
                if (an_out != 8'hFF && an_out != prev_an) begin
                    digit_starts++;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        checkOutput("digit_anode", an_out, e[15:8]);
                        checkOutput("digit_seg", seg_out, e[7:0]);
                    end
                end
                if (prev_an != 8'hFF && an_out != prev_an)
                    checkOutput("dwell_len", run, TB_DIV);
                if (an_out == 8'hFF)
                    run = 0;
                else if (an_out == prev_an)
                    run++;
                else
                    run = 1;
                if (frame_done) begin
                    checkOutput("fd_after_digit7", prev_an, 8'h7F);
                    checkOutput("fd_width", prev_fd, 1'b0);
                    checkOutput("fd_gap_anode", an_out, 8'hFF);
                    if (last_fd >= 0)
                        checkOutput("frame_period", cyc - last_fd, TB_PERIOD);
                    last_fd = cyc;
                end
                prev_an = an_out;
                prev_fd = frame_done;
            end
        end
    end

    initial begin
        int starts_snapshot;
        bit seen;
        upd_if.upd_valid = 1'b0;
        upd_if.upd_data  = '0;
        upd_if.upd_blank = '0;
        upd_if.upd_dp    = '0;

        // Asynchronous reset with the clock stopped.
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_an", an_out, 8'hFF);
        checkOutput("rst_seg", seg_out, 8'hFF);
        checkOutput("rst_ready", upd_if.upd_ready, 1'b1);
        checkOutput("rst_fd", frame_done, 1'b0);
        #5 clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("idle_digits", digit_starts, 0);
        checkOutput("idle_an", an_out, 8'hFF);
        checkOutput("idle_seg", seg_out, 8'hFF);
        checkOutput("idle_ready", upd_if.upd_ready, 1'b1);

        // First frame, then wrap into digits 0 and 1 of the repeated frame.
        $display("[TB] first frame 76543210");
        exp_q.push_back({8'hFE, 8'hC0});
        exp_q.push_back({8'hFD, 8'hF9});
        exp_q.push_back({8'hFB, 8'hA4});
        exp_q.push_back({8'hF7, 8'hB0});
        exp_q.push_back({8'hEF, 8'h99});
        exp_q.push_back({8'hDF, 8'h92});
        exp_q.push_back({8'hBF, 8'h82});
        exp_q.push_back({8'h7F, 8'hF8});
        exp_q.push_back({8'hFE, 8'hC0});
        exp_q.push_back({8'hFD, 8'hF9});
        applyStimulus(32'h76543210, 8'h00, 8'h00);
        waitQueueEmpty(200);

        // Back-pressure: new frame accepted during digit 2.
        $display("[TB] back-pressure frame FFFFFFFF");
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (an_out == 8'hFB) seen = 1;
        end
        if (!seen) begin
            total_cnt++;
            $display("[TB] FAIL wait_digit2: got an_out %0h, expected FB", an_out);
        end
        exp_q.push_back({8'hF7, 8'hB0});
        exp_q.push_back({8'hEF, 8'h99});
        exp_q.push_back({8'hDF, 8'h92});
        exp_q.push_back({8'hBF, 8'h82});
        exp_q.push_back({8'h7F, 8'hF8});
        exp_q.push_back({8'hFE, 8'h8E});
        exp_q.push_back({8'hFD, 8'h8E});
        applyStimulus(32'hFFFF_FFFF, 8'h00, 8'h00);
        checkOutput("ready_low_after_accept", upd_if.upd_ready, 1'b0);
        upd_if.upd_valid = 1'b1;
        upd_if.upd_data  = 32'h1111_1111;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            checkOutput("ready_held_low", upd_if.upd_ready, 1'b0);
            if (frame_done) seen = 1;
        end
        if (!seen) begin
            total_cnt++;
            $display("[TB] FAIL wait_frame_done: got no frame_done, expected one within 100 cycles");
        end
        @(posedge clk);
        #1 upd_if.upd_valid = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_boundary", upd_if.upd_ready, 1'b1);

        // Blank digit 1, decimal point on digit 0.
        $display("[TB] blank/dp frame");
        exp_q.push_back({8'hFB, 8'h8E});
        exp_q.push_back({8'hF7, 8'h8E});
        exp_q.push_back({8'hEF, 8'h8E});
        exp_q.push_back({8'hDF, 8'h8E});
        exp_q.push_back({8'hBF, 8'h8E});
        exp_q.push_back({8'h7F, 8'h8E});
        exp_q.push_back({8'hFE, 8'h40});
        exp_q.push_back({8'hFD, 8'hFF});
        exp_q.push_back({8'hFB, 8'hA4});
        applyStimulus(32'h76543210, 8'h02, 8'h01);
        waitQueueEmpty(200);

        // Reset mid-dwell discards the pending frame.
        $display("[TB] reset with pending frame");
        applyStimulus(32'h89AB_CDEF, 8'h00, 8'h00);
        checkOutput("pending_ready_low", upd_if.upd_ready, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_an", an_out, 8'hFF);
        checkOutput("midrst_seg", seg_out, 8'hFF);
        checkOutput("midrst_ready", upd_if.upd_ready, 1'b1);
        checkOutput("midrst_fd", frame_done, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        starts_snapshot = digit_starts;
        repeat (50) @(negedge clk);
        checkOutput("post_rst_no_digits", digit_starts, starts_snapshot);
        checkOutput("post_rst_an", an_out, 8'hFF);

        exp_q.push_back({8'hFE, 8'h88});
        exp_q.push_back({8'hFD, 8'hC0});
        applyStimulus(32'h0000_000A, 8'h00, 8'h00);
        waitQueueEmpty(100);

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
